fetch_queue: RTL and testbench

Parametrised instruction queue that sits between instruction fetch and instruction decode, replacing the single-entry IF/ID register. It buffers up to DEPTH fetched {pc, instruction} pairs, decoupling fetch from decode stalls with a valid/ready handshake on both sides. It also supports a single-cycle flush on a taken branch, presenting a NOP to decode whenever no valid entry is available.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. It is a DEPTH-entry circular buffer of
// {pc, instr} with valid/ready on both sides and a single-cycle flush for taken branches.
module fetch_queue #(
  parameter int                XLEN      = 32,
  parameter int                DEPTH     = 4,
  parameter logic [XLEN-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       inValid,
  input  logic [XLEN-1:0]            pcIn,
  input  logic [XLEN-1:0]            instrIn,
  output logic                       inReady,
  output logic                       outValid,
  output logic [XLEN-1:0]            pcOut,
  output logic [XLEN-1:0]            instrOut,
  input  logic                       outReady,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                flushCount
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [15:0]                  flush_cnt_q, flush_cnt_d;
  logic [DEPTH-1:0][XLEN-1:0]   pc_mem_q, pc_mem_d, instr_mem_q, instr_mem_d;
  logic                         full, empty, push, pop;

  // The pointers carry one extra wrap bit, which lets the queue tell full apart from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign push  = inValid && !full;
  assign pop   = outReady && !empty;

  assign inReady    = !full;
  assign outValid   = !empty;
  assign pcOut      = empty ? '0 : pc_mem_q[rd_ptr_q[IW-1:0]];
  assign instrOut   = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q[IW-1:0]];
  assign count      = count_q;
  assign flushCount = flush_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (flush) begin
      // Any push or pop in the same cycle belongs to the wrong path and is dropped.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      if (count_q != '0 && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q[IW-1:0]]    = pcIn;
        instr_mem_d[wr_ptr_q[IW-1:0]] = instrIn;
        wr_ptr_d                      = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
      pc_mem_q    <= '0;
      instr_mem_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. It runs directed steps and then a randomized run.
// Both are checked against a queue-based model of the fetch/decode buffer.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk, resetn, inValid, inReady, outValid, outReady, flush;
  logic [31:0]   pcIn, instrIn, pcOut, instrOut;
  logic [CW-1:0] count;
  logic [15:0]   flushCount;

  int errors = 0;
  int checks = 0;
  logic [63:0] mq[$];
  int fcm = 0;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .resetn(resetn), .inValid(inValid), .pcIn(pcIn), .instrIn(instrIn),
    .inReady(inReady), .outValid(outValid), .pcOut(pcOut), .instrOut(instrOut),
    .outReady(outReady), .flush(flush), .count(count), .flushCount(flushCount)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".outValid"}, 32'(outValid), 32'(n != 0));
    check({tag, ".inReady"}, 32'(inReady), 32'(n < DEPTH));
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".pcOut"}, pcOut, (n != 0) ? mq[0][63:32] : 32'h0);
    check({tag, ".instrOut"}, instrOut, (n != 0) ? mq[0][31:0] : NOP);
    check({tag, ".flushCount"}, 32'(flushCount), 32'(fcm));
  endtask

  // Drive one cycle of inputs, let the edge occur, advance the model, then compare.
  task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic ordy, input logic fl);
    logic acc, pp;
    inValid = iv; pcIn = pc; instrIn = ins; outReady = ordy; flush = fl;
    acc = iv && (mq.size() < DEPTH) && !fl;
    pp  = ordy && (mq.size() > 0) && !fl;
    @(posedge clk); #1;
    if (fl) begin
      if (mq.size() != 0 && fcm != 16'hFFFF) fcm++;
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back({pc, ins});
    end
    check_all(tag);
  endtask

  initial begin
    resetn = 0; inValid = 0; pcIn = 0; instrIn = 0; outReady = 0; flush = 0;
    #1 check_all("reset");
    @(posedge clk); #1 resetn = 1;

    // Three pushes, no pops.
    step("push0", 1, 32'h0, 32'hA, 0, 0);
    step("push1", 1, 32'h4, 32'hB, 0, 0);
    step("push2", 1, 32'h8, 32'hC, 0, 0);
    check("cnt3", 32'(count), 32'd3);
    check("head3", instrOut, 32'hA);
    // Fill up, then attempt one more push that must be refused.
    step("push3", 1, 32'hC, 32'hD, 0, 0);
    check("full_rdy", 32'(inReady), 32'd0);
    step("push4", 1, 32'h10, 32'hE, 0, 0);
    check("full_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("pop_order", instrOut, 32'hA + 32'(i));
      step("pop", 0, 0, 0, 1, 0);
    end
    check("drained_nop", instrOut, NOP);

    // Streaming across the pointer wrap.
    step("prime", 1, 32'h100, 32'h1000, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      check("stream_head", instrOut, 32'h1000 + 32'(i - 1));
      step("stream", 1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1, 0);
      check("stream_cnt", 32'(count), 32'd1);
    end
    step("stream_end", 0, 0, 0, 1, 0);

    // Flush with three entries, plus a push and a pop in the same cycle.
    for (int i = 0; i < 3; i++) step("fill", 1, 32'h200 + 32'(4 * i), 32'h20 + 32'(i), 0, 0);
    step("flush", 1, 32'h300, 32'h30, 1, 1);
    check("flush_fc", 32'(flushCount), 32'd1);
    step("flush_empty", 0, 0, 0, 0, 1);
    check("flush_empty_fc", 32'(flushCount), 32'd1);

    // Asynchronous reset between edges while entries are queued.
    step("pre_rst0", 1, 32'h400, 32'h40, 0, 0);
    step("pre_rst1", 1, 32'h404, 32'h41, 0, 0);
    inValid = 0;
    #3 resetn = 0;
    #1;
    mq.delete(); fcm = 0;
    check_all("async_rst");
    #2 resetn = 1;

    // A pop on an empty queue does not happen, but the push still lands.
    step("empty_pushpop", 1, 32'h500, 32'h50, 1, 0);
    check("epp_cnt", 32'(count), 32'd1);

    // Randomized run.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
